// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the EX-stage multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } muldiv_state_e;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// o_done flags the final iteration; o_quotient/o_remainder show that iteration's result.
module muldiv_div_core #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvsr;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;

    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, dvsr};
        borrow  = diff[WIDTH+1];
        // Restore on borrow: the partial remainder stays the shifted value.
        rem_nxt = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], ~borrow};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            quo  <= '0;
            dvsr <= '0;
        end else if (i_start) begin
            busy <= 1'b1;
            cnt  <= CNT_W'(WIDTH);
            rem  <= '0;
            quo  <= i_dividend;
            dvsr <= i_divisor;
        end else if (busy) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) busy <= 1'b0;
        end
    end

    assign o_busy      = busy;
    assign o_done      = busy & (cnt == CNT_W'(1));
    assign o_quotient  = quo_nxt;
    assign o_remainder = rem_nxt;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit holding HI/LO, with pipeline stall generation.
// Define MULDIV_FAST_MUL_EN for single-cycle (DSP) MULT/MULTU; default is iterative.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    input  logic             i_hilo_read,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_stall,
    output logic             o_done
);

    muldiv_state_e state, state_nxt;

    logic               start_q, start_arith, start_mt, op_signed, op_div;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [CNT_W-1:0]   cnt;
    logic               is_div, neg_q, neg_r, div0;
    logic [WIDTH-1:0]   src_a_raw, mcand, hi, lo;
    logic [2*WIDTH-1:0] prod, mul_step, mul_raw, mul_res;
    logic [WIDTH:0]     mul_upper;
    logic               mul_last, finish;
    logic               div_busy, div_done;
    logic [WIDTH-1:0]   div_quo, div_rem, quo_res, rem_res;

    assign o_stall = (state == S_BUSY) & (i_start | i_hilo_read);
    assign o_busy  = (state == S_BUSY);
    assign o_done  = (state == S_DONE);
    assign o_hi    = hi;
    assign o_lo    = lo;

    always_comb begin
        start_q     = i_start & ~i_flush & ~o_stall;
        start_arith = start_q & (i_op <= OP_DIVU);
        start_mt    = start_q & ((i_op == OP_MTHI) | (i_op == OP_MTLO));
        op_signed   = (i_op == OP_MULT) | (i_op == OP_DIV);
        op_div      = (i_op == OP_DIV) | (i_op == OP_DIVU);
        sign_a      = op_signed & i_src_a[WIDTH-1];
        sign_b      = op_signed & i_src_b[WIDTH-1];
        mag_a       = sign_a ? -i_src_a : i_src_a;
        mag_b       = sign_b ? -i_src_b : i_src_b;
    end

    // Shift-add: the low half of prod starts as the multiplier and is consumed LSB first.
    always_comb begin
        mul_upper = prod[0] ? ({1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand})
                            : {1'b0, prod[2*WIDTH-1:WIDTH]};
        mul_step  = {mul_upper, prod[WIDTH-1:1]};
`ifdef MULDIV_FAST_MUL_EN
        mul_raw   = (2*WIDTH)'(mcand) * (2*WIDTH)'(prod[WIDTH-1:0]);
        mul_last  = 1'b1;
`else
        mul_raw   = mul_step;
        mul_last  = (cnt == CNT_W'(1));
`endif
        mul_res   = neg_q ? -mul_raw : mul_raw;
        quo_res   = neg_q ? -div_quo : div_quo;
        rem_res   = neg_r ? -div_rem : div_rem;
        finish    = (state == S_BUSY) & (is_div ? (div_busy & div_done) : mul_last);
    end

    muldiv_div_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_div_core (
        .clk         (clk),
        .reset       (reset),
        .i_start     (start_arith & op_div),
        .i_dividend  (mag_a),
        .i_divisor   (mag_b),
        .o_busy      (div_busy),
        .o_done      (div_done),
        .o_quotient  (div_quo),
        .o_remainder (div_rem)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: next-state gets a default before the case so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_arith) state_nxt = S_BUSY;
            S_BUSY:  if (finish)      state_nxt = S_DONE;
            S_DONE:  state_nxt = start_arith ? S_BUSY : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            is_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div0      <= 1'b0;
            src_a_raw <= '0;
            mcand     <= '0;
            prod      <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            if (start_arith) begin
                cnt       <= CNT_W'(WIDTH);
                is_div    <= op_div;
                neg_q     <= sign_a ^ sign_b;
                neg_r     <= sign_a;
                div0      <= (i_src_b == '0);
                src_a_raw <= i_src_a;
                mcand     <= mag_a;
                prod      <= {{WIDTH{1'b0}}, mag_b};
            end else if (state == S_BUSY) begin
                cnt  <= cnt - 1'b1;
                prod <= mul_step;
            end

            // Divide-by-zero bypasses sign fix-up so HI keeps the raw dividend.
            if (finish) begin
                if (is_div) begin
                    lo <= div0 ? WIDTH'(DIV0_QUOT) : quo_res;
                    hi <= div0 ? src_a_raw : rem_res;
                end else begin
                    {hi, lo} <= mul_res;
                end
            end else if (start_mt) begin
                if (i_op == OP_MTHI) hi <= i_src_a;
                else                 lo <= i_src_a;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: scoreboard of expected {HI,LO} per operation.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_flush, i_start, i_hilo_read;
    logic [2:0]  i_op;
    logic [31:0] i_src_a, i_src_b;
    logic [31:0] o_hi, o_lo;
    logic        o_busy, o_stall, o_done;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] sb[$];

    ex_muldiv_unit dut (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (i_flush),
        .i_start     (i_start),
        .i_op        (i_op),
        .i_src_a     (i_src_a),
        .i_src_b     (i_src_b),
        .i_hilo_read (i_hilo_read),
        .o_hi        (o_hi),
        .o_lo        (o_lo),
        .o_busy      (o_busy),
        .o_stall     (o_stall),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     q, r;
        case (op)
            3'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            3'd1: return {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return {32'b0, INT_MIN};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'b0;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] op);
        return (op <= 3'd1) ? MUL_LAT : DIV_LAT;
    endfunction

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
        @(negedge clk);
        i_start = 1'b1; i_op = op; i_src_a = a; i_src_b = b;
        if (push) sb.push_back(model(op, a, b));
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Called at the negedge after the start edge; returns at the negedge where o_done is seen.
    task automatic wait_done(input string tag, input int exp_lat, input bit watch_stall);
        int          cyc = 1;
        int          stall_bad = 0;
        logic [63:0] e;
        while (!o_done && cyc < 200) begin
            if (watch_stall && o_busy && !o_stall) stall_bad++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, 64'(o_done), 64'd1);
        check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        if (watch_stall) begin
            check({tag, "_stall_busy"}, 64'(stall_bad), 64'd0);
            check({tag, "_stall_done"}, 64'(o_stall), 64'd0);
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_hilo"}, {o_hi, o_lo}, e);
        end
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          done_seen;

        reset = 1'b1; i_flush = 1'b0; i_start = 1'b0; i_hilo_read = 1'b0;
        i_op = 3'd0; i_src_a = '0; i_src_b = '0;
        repeat (3) @(negedge clk);
        check("rst_hi", 64'(o_hi), 64'd0);
        check("rst_lo", 64'(o_lo), 64'd0);
        check("rst_ctl", {61'b0, o_busy, o_stall, o_done}, 64'd0);
        reset = 1'b0;

        start_op(OP_MULT, 32'hFFFF_FFFE, 32'd7, 1'b1);
        wait_done("mult_neg", MUL_LAT, 1'b0);
        start_op(OP_MULTU, 32'hFFFF_FFFE, 32'd7, 1'b1);
        wait_done("multu", MUL_LAT, 1'b0);
        start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done("div_neg", DIV_LAT, 1'b0);
        start_op(OP_DIVU, 32'd100, 32'd0, 1'b1);
        wait_done("divu_zero", DIV_LAT, 1'b0);
        start_op(OP_DIV, 32'hFFFF_FF00, 32'd0, 1'b1);
        wait_done("div_zero_neg", DIV_LAT, 1'b0);
        start_op(OP_DIV, INT_MIN, 32'hFFFF_FFFF, 1'b1);
        wait_done("div_ovf", DIV_LAT, 1'b0);
        start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("multu_max", MUL_LAT, 1'b0);

        // Dependent MFLO held behind an in-flight multiply.
        start_op(OP_MULT, 32'd3, 32'd5, 1'b1);
        i_hilo_read = 1'b1;
        wait_done("mfhi_stall", MUL_LAT, 1'b1);
        check("mfhi_lo15", 64'(o_lo), 64'd15);
        i_hilo_read = 1'b0;

        // Next mul/div held by stall, accepted in the DONE cycle.
        start_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 1'b1);
        i_start = 1'b1; i_op = OP_MULTU; i_src_a = 32'd6; i_src_b = 32'd7;
        sb.push_back(model(OP_MULTU, 32'd6, 32'd7));
        wait_done("div_held", DIV_LAT, 1'b1);
        @(negedge clk);
        i_start = 1'b0;
        check("accept_in_done", 64'(o_busy), 64'd1);
        wait_done("multu_b2b", MUL_LAT, 1'b0);

        // MTLO / MTHI and flush.
        start_op(OP_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0);
        check("mtlo_lo", 64'(o_lo), 64'hDEAD_BEEF);
        check("mtlo_ctl", {62'b0, o_busy, o_done}, 64'd0);
        start_op(OP_MTHI, 32'h1234_5678, 32'd0, 1'b0);
        check("mthi_hi", 64'(o_hi), 64'h1234_5678);
        @(negedge clk);
        i_start = 1'b1; i_flush = 1'b1; i_op = OP_MTLO; i_src_a = 32'h0BAD_F00D;
        @(negedge clk);
        i_op = OP_MULT; i_src_a = 32'd3; i_src_b = 32'd5;
        check("flush_mtlo", 64'(o_lo), 64'hDEAD_BEEF);
        @(negedge clk);
        i_start = 1'b0; i_flush = 1'b0;
        check("flush_mult", {62'b0, o_busy, o_done}, 64'd0);
        start_op(3'd6, 32'h5555_5555, 32'd1, 1'b0);
        check("reserved_op", {o_busy, o_done, o_lo}, {2'b00, 32'hDEAD_BEEF});

        // Reset in the middle of a divide.
        start_op(OP_DIV, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_hilo", {o_hi, o_lo}, 64'd0);
        check("midrst_ctl", {62'b0, o_busy, o_done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_done) done_seen++;
        end
        check("midrst_no_done", 64'(done_seen), 64'd0);
        start_op(OP_DIVU, 32'd9, 32'd4, 1'b1);
        wait_done("divu_after_rst", DIV_LAT, 1'b0);

        // Random arithmetic ops.
        for (int k = 0; k < 8; k++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (k == 5) ? 32'd0 : ((k % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
            if (k % 3 == 1) ra = -ra;
            start_op(rop, ra, rb, 1'b1);
            wait_done($sformatf("rand%0d_op%0d", k, rop), lat_of(rop), 1'b0);
        end

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
